// File: rtl/uart_fifo_bridge_if.sv
// CPU-side bus of the uart FIFO bridge: push/pop strobes, FIFO head data and status.
// The CPU side uses the master modport and the bridge uses the slave modport.
interface uart_fifo_bridge_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en_i;
    logic [7:0]            wr_data_i;
    logic                  rd_en_i;
    logic [7:0]            rd_data_o;
    logic                  clear_flags_i;
    logic                  tx_full_o;
    logic                  tx_empty_o;
    logic                  rx_full_o;
    logic                  rx_empty_o;
    logic [DEPTH_LOG2:0]   tx_count_o;
    logic [DEPTH_LOG2:0]   rx_count_o;
    logic                  tx_overflow_o;
    logic                  rx_overrun_o;

    modport master (
        output wr_en_i, wr_data_i, rd_en_i, clear_flags_i,
        input  rd_data_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o,
        input  tx_count_o, rx_count_o, tx_overflow_o, rx_overrun_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, rd_en_i, clear_flags_i,
        output rd_data_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o,
        output tx_count_o, rx_count_o, tx_overflow_o, rx_overrun_o
    );
endinterface

// File: rtl/uart_fifo_bridge.sv
// TX/RX byte FIFOs between the CPU bus and an 8N1 uart core, with a small
// launcher FSM that feeds queued bytes into the core through its start/busy handshake.
//
//  state  | meaning
//  -------+------------------------------------------------------------------
//  IDLE   | waiting for a queued byte and an idle core; launches and pops
//  LAUNCH | start pulse is on the wire this cycle; drops it next edge
//  GUARD  | one blind cycle so a core with registered busy is tolerated
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    uart_fifo_bridge_if.slave   bus,
    output logic [7:0]          uart_tx_data_o,
    output logic                uart_tx_start_o,
    input  logic                uart_tx_busy_i,
    input  logic [7:0]          uart_rx_data_i,
    input  logic                uart_rx_ready_i
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        GUARD  = 2'd2
    } launch_state_t;

    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr;
    logic [DEPTH_LOG2:0]   tx_count;

    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr;
    logic [DEPTH_LOG2:0]   rx_count;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_overflow, rx_overrun;
    logic tx_drop, rx_drop;

    launch_state_t state, state_nxt;
    logic          launch;

    assign tx_full  = (tx_count == FULL_COUNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_COUNT);
    assign rx_empty = (rx_count == '0);

    assign tx_push = bus.wr_en_i && !tx_full;
    assign tx_pop  = launch;
    assign tx_drop = bus.wr_en_i && tx_full;

    // A full RX FIFO still accepts a byte when the CPU pops in the same cycle.
    assign rx_pop  = bus.rd_en_i && !rx_empty;
    assign rx_push = uart_rx_ready_i && (!rx_full || bus.rd_en_i);
    assign rx_drop = uart_rx_ready_i && rx_full && !bus.rd_en_i;

    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= bus.wr_data_i;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= uart_rx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            if (tx_drop) begin
                tx_overflow <= 1'b1;
            end else if (bus.clear_flags_i) begin
                tx_overflow <= 1'b0;
            end
            if (rx_drop) begin
                rx_overrun <= 1'b1;
            end else if (bus.clear_flags_i) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty && !uart_tx_busy_i) begin
                    launch    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH:  state_nxt = GUARD;
            GUARD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Data stays registered until the next launch so the core may sample it late.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            uart_tx_start_o <= 1'b0;
            uart_tx_data_o  <= 8'h00;
        end else begin
            uart_tx_start_o <= launch;
            if (launch) begin
                uart_tx_data_o <= tx_mem[tx_rd_ptr];
            end
        end
    end

    assign bus.rd_data_o     = rx_mem[rx_rd_ptr];
    assign bus.tx_full_o     = tx_full;
    assign bus.tx_empty_o    = tx_empty;
    assign bus.rx_full_o     = rx_full;
    assign bus.rx_empty_o    = rx_empty;
    assign bus.tx_count_o    = tx_count;
    assign bus.rx_count_o    = rx_count;
    assign bus.tx_overflow_o = tx_overflow;
    assign bus.rx_overrun_o  = rx_overrun;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: scoreboard queues for TX launches and RX reads,
// plus a simple uart core model whose busy window length is set per step.
module tb_uart_fifo_bridge;
    localparam int DL = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] uart_tx_data;
    logic       uart_tx_start;
    logic       uart_tx_busy;
    logic [7:0] uart_rx_data;
    logic       uart_rx_ready;

    always #5 clk_i = ~clk_i;

    uart_fifo_bridge_if #(.DEPTH_LOG2(DL)) bus ();

    uart_fifo_bridge #(.DEPTH_LOG2(DL)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .bus             (bus),
        .uart_tx_data_o  (uart_tx_data),
        .uart_tx_start_o (uart_tx_start),
        .uart_tx_busy_i  (uart_tx_busy),
        .uart_rx_data_i  (uart_rx_data),
        .uart_rx_ready_i (uart_rx_ready)
    );

    logic [7:0] tx_exp [$];
    logic [7:0] rx_exp [$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cnt = 0;
    int last_start = -1000;
    int busy_cnt = 0;
    int busy_len = 0;
    logic busy_force = 1'b0;
    logic prev_start = 1'b0;
    int wr_cyc;
    int s;

    // Core model: busy includes the start pulse, then stays high busy_len cycles.
    assign uart_tx_busy = uart_tx_start | (busy_cnt != 0) | busy_force;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (uart_tx_start) begin
            check("start_width", 32'(prev_start), 32'd0);
            check("start_spacing", 32'(cyc - last_start >= 3), 32'd1);
            check("start_while_busy", 32'(busy_cnt), 32'd0);
            if (tx_exp.size() == 0) begin
                check("unexpected_start_queue", 32'(tx_exp.size()), 32'd1);
            end else begin
                check("tx_data", 32'(uart_tx_data), 32'(tx_exp.pop_front()));
            end
            start_cnt++;
            last_start = cyc;
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        prev_start = uart_tx_start;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(start_cnt >= target), 32'd1);
    endtask

    task automatic rx_fill(input logic [7:0] base, input int num, input logic track);
        for (int i = 0; i < num; i++) begin
            uart_rx_ready = 1'b1;
            uart_rx_data  = 8'(base + 8'(i));
            if (track) rx_exp.push_back(uart_rx_data);
            tick();
        end
        uart_rx_ready = 1'b0;
    endtask

    task automatic rx_drain(input int num);
        for (int i = 0; i < num; i++) begin
            check("rx_data", 32'(bus.rd_data_o), 32'(rx_exp.pop_front()));
            bus.rd_en_i = 1'b1;
            tick();
            bus.rd_en_i = 1'b0;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        bus.wr_en_i = 1'b0;
        bus.wr_data_i = 8'h00;
        bus.rd_en_i = 1'b0;
        bus.clear_flags_i = 1'b0;
        uart_rx_data = 8'h00;
        uart_rx_ready = 1'b0;
        tick();
        tick();
        check("rst_tx_empty", 32'(bus.tx_empty_o), 32'd1);
        check("rst_rx_empty", 32'(bus.rx_empty_o), 32'd1);
        check("rst_tx_full", 32'(bus.tx_full_o), 32'd0);
        check("rst_rx_full", 32'(bus.rx_full_o), 32'd0);
        check("rst_tx_count", 32'(bus.tx_count_o), 32'd0);
        check("rst_rx_count", 32'(bus.rx_count_o), 32'd0);
        check("rst_flags", 32'({bus.tx_overflow_o, bus.rx_overrun_o}), 32'd0);
        check("rst_start", 32'(uart_tx_start), 32'd0);
        check("rst_tx_data", 32'(uart_tx_data), 32'd0);
        rst_i = 1'b0;
        tick();

        // single byte, idle core: start two edges after the write
        busy_len = 0;
        bus.wr_en_i = 1'b1;
        bus.wr_data_i = 8'h55;
        tx_exp.push_back(8'h55);
        wr_cyc = cyc;
        tick();
        bus.wr_en_i = 1'b0;
        wait_starts(1, 10, "t1_start_timeout");
        check("t1_latency", 32'(last_start - wr_cyc), 32'd2);
        repeat (5) tick();
        check("t1_one_pulse", 32'(start_cnt), 32'd1);
        check("t1_tx_empty", 32'(bus.tx_empty_o), 32'd1);
        check("t1_data_held", 32'(uart_tx_data), 32'h55);

        // three bytes with a long busy window after each start
        busy_len = 100;
        for (int i = 1; i <= 3; i++) begin
            bus.wr_en_i = 1'b1;
            bus.wr_data_i = 8'(i);
            tx_exp.push_back(bus.wr_data_i);
            tick();
        end
        bus.wr_en_i = 1'b0;
        wait_starts(4, 400, "t2_start_timeout");
        check("t2_queue_drained", 32'(tx_exp.size()), 32'd0);
        repeat (110) tick();
        check("t2_pulse_count", 32'(start_cnt), 32'd4);
        busy_len = 0;

        // fill TX while the core is busy, overflow and flag clearing
        busy_force = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_en_i = 1'b1;
            bus.wr_data_i = 8'(8'h30 + 8'(i));
            if (i < 16) tx_exp.push_back(bus.wr_data_i);
            tick();
        end
        bus.wr_en_i = 1'b0;
        check("t3_tx_count", 32'(bus.tx_count_o), 32'd16);
        check("t3_tx_full", 32'(bus.tx_full_o), 32'd1);
        check("t3_overflow", 32'(bus.tx_overflow_o), 32'd1);
        bus.clear_flags_i = 1'b1;
        tick();
        bus.clear_flags_i = 1'b0;
        check("t3_overflow_cleared", 32'(bus.tx_overflow_o), 32'd0);
        check("t3_count_kept", 32'(bus.tx_count_o), 32'd16);
        bus.clear_flags_i = 1'b1;
        bus.wr_en_i = 1'b1;
        bus.wr_data_i = 8'hEE;
        tick();
        bus.clear_flags_i = 1'b0;
        bus.wr_en_i = 1'b0;
        check("t3_set_wins", 32'(bus.tx_overflow_o), 32'd1);
        bus.clear_flags_i = 1'b1;
        tick();
        bus.clear_flags_i = 1'b0;
        busy_force = 1'b0;
        s = start_cnt;
        wait_starts(s + 16, 120, "t3_drain_timeout");
        repeat (4) tick();
        check("t3_tx_empty", 32'(bus.tx_empty_o), 32'd1);
        check("t3_overflow_off", 32'(bus.tx_overflow_o), 32'd0);

        // RX fill, overrun, in-order read-out
        uart_rx_ready = 1'b1;
        uart_rx_data = 8'hA0;
        rx_exp.push_back(8'hA0);
        tick();
        uart_rx_ready = 1'b0;
        check("t4_fwft_data", 32'(bus.rd_data_o), 32'hA0);
        check("t4_fwft_nonempty", 32'(bus.rx_empty_o), 32'd0);
        rx_fill(8'hA1, 15, 1'b1);
        rx_fill(8'hFF, 1, 1'b0);
        check("t4_rx_full", 32'(bus.rx_full_o), 32'd1);
        check("t4_rx_count", 32'(bus.rx_count_o), 32'd16);
        check("t4_overrun", 32'(bus.rx_overrun_o), 32'd1);
        rx_drain(16);
        check("t4_rx_empty", 32'(bus.rx_empty_o), 32'd1);
        bus.clear_flags_i = 1'b1;
        tick();
        bus.clear_flags_i = 1'b0;
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        check("t4_empty_read_count", 32'(bus.rx_count_o), 32'd0);
        check("t4_empty_read_noflag", 32'(bus.rx_overrun_o), 32'd0);

        // full RX with simultaneous push and pop, across pointer wrap
        rx_fill(8'hB0, 16, 1'b1);
        check("t5_pre_count", 32'(bus.rx_count_o), 32'd16);
        uart_rx_ready = 1'b1;
        uart_rx_data = 8'h77;
        rx_exp.push_back(8'h77);
        check("t5_head", 32'(bus.rd_data_o), 32'(rx_exp.pop_front()));
        bus.rd_en_i = 1'b1;
        tick();
        uart_rx_ready = 1'b0;
        bus.rd_en_i = 1'b0;
        check("t5_count_same", 32'(bus.rx_count_o), 32'd16);
        check("t5_no_overrun", 32'(bus.rx_overrun_o), 32'd0);
        rx_drain(15);
        check("t5_last_is_77", 32'(bus.rd_data_o), 32'h77);
        rx_drain(1);
        check("t5_rx_empty", 32'(bus.rx_empty_o), 32'd1);

        // reset with TX bytes queued and a start pulse on the wire
        rx_fill(8'hC0, 17, 1'b0);
        check("t6_pre_overrun", 32'(bus.rx_overrun_o), 32'd1);
        busy_force = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_en_i = 1'b1;
            bus.wr_data_i = 8'(8'h60 + 8'(i));
            tx_exp.push_back(bus.wr_data_i);
            tick();
        end
        bus.wr_en_i = 1'b0;
        busy_force = 1'b0;
        tick();
        check("t6_pre_start", 32'(uart_tx_start), 32'd1);
        check("t6_pre_tx_count", 32'(bus.tx_count_o), 32'd5);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t6_tx_count", 32'(bus.tx_count_o), 32'd0);
        check("t6_rx_count", 32'(bus.rx_count_o), 32'd0);
        check("t6_start", 32'(uart_tx_start), 32'd0);
        check("t6_flags", 32'({bus.tx_overflow_o, bus.rx_overrun_o}), 32'd0);
        check("t6_tx_data", 32'(uart_tx_data), 32'd0);
        tx_exp.delete();
        rx_exp.delete();
        s = start_cnt;
        repeat (30) tick();
        check("t6_no_more_starts", 32'(start_cnt), 32'(s));
        check("t6_tx_empty", 32'(bus.tx_empty_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
